// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one binary-weighted stage (16,8,4,2,1) per clock,
// giving a fixed five-cycle latency with a valid/ready handshake on both sides.
`timescale 1ns/1ps
module shift_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_operand,
    input  logic [4:0]       in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_shamt;
    logic [1:0]         r_op;

    logic               w_accept;
    logic               w_last_stage;
    logic               w_stage_en;
    logic [SHAMT_W-1:0] w_stage_amt;
    logic [WIDTH-1:0]   w_shifted;

    assign w_accept     = (r_state == IDLE) && in_valid;
    assign w_last_stage = (r_count == CNT_W'(STAGES - 1));

    // Stage k shifts by 16>>k, gated by shamt bit (4-k)
    always_comb begin
        w_stage_en  = 1'b0;
        w_stage_amt = '0;
        case (r_count)
            3'd0:    begin w_stage_en = r_shamt[4]; w_stage_amt = 5'd16; end
            3'd1:    begin w_stage_en = r_shamt[3]; w_stage_amt = 5'd8;  end
            3'd2:    begin w_stage_en = r_shamt[2]; w_stage_amt = 5'd4;  end
            3'd3:    begin w_stage_en = r_shamt[1]; w_stage_amt = 5'd2;  end
            3'd4:    begin w_stage_en = r_shamt[0]; w_stage_amt = 5'd1;  end
            default: begin w_stage_en = 1'b0;       w_stage_amt = '0;    end
        endcase
    end

    // Reserved op code passes the operand through untouched
    always_comb begin
        w_shifted = r_work;
        case (r_op)
            OP_SLL:  w_shifted = r_work << w_stage_amt;
            OP_SRA:  w_shifted = WIDTH'($signed(r_work) >>> w_stage_amt);
            OP_SRL:  w_shifted = r_work >> w_stage_amt;
            default: w_shifted = r_work;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)     w_next_state = SHIFT;
            SHIFT:   if (w_last_stage) w_next_state = DONE;
            DONE:    if (out_ready)    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (r_state == IDLE);
        busy       = (r_state != IDLE);
        out_valid  = (r_state == DONE);
        out_result = r_work;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_work  <= '0;
            r_shamt <= '0;
            r_op    <= '0;
        end else if (w_accept) begin
            r_count <= '0;
            r_work  <= in_operand;
            r_shamt <= in_shamt;
            r_op    <= in_op;
        end else if (r_state == SHIFT) begin
            r_count <= r_count + 3'd1;
            if (w_stage_en) begin
                r_work <= w_shifted;
            end
        end
    end

endmodule
